// File: rtl/debug_console.sv
// -----------------------------------------------------------------------------
// debug_console
//
// Scans a ROWS x COLS character console one cell per enabled cycle and writes
// a text dump of NUM_FIELDS 32-bit fields into it. Row r < NUM_FIELDS shows
// "TT: HHHHHHHH" (two tag characters, colon, space, eight uppercase hex
// digits); every other cell is 0x00. Field values come from a snapshot taken
// at the start of each frame, so one frame is always coherent. Tags are live.
//
// Ports
//   clk_i           sole clock, rising edge
//   rst_i           asynchronous, active-high reset
//   enable_i        scanner advances and writes one cell when high
//   freeze_i        inhibits the frame-start snapshot while high
//   field_data_i    packed fields, field k = [32k+31:32k]
//   field_tag_i     two ASCII chars per field, [16k+15:16k+8] is the first
//   console_addr_o  cell address (row*COLS+col) being written
//   console_data_o  ASCII character for console_addr_o
//   console_write_o write strobe
//   frame_done_o    one-cycle pulse with the last cell of a frame
// -----------------------------------------------------------------------------
module debug_console #(
    parameter int NUM_FIELDS = 4,
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_W     = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       freeze_i,
    input  logic [NUM_FIELDS*32-1:0]   field_data_i,
    input  logic [NUM_FIELDS*16-1:0]   field_tag_i,
    output logic [ADDR_W-1:0]          console_addr_o,
    output logic [7:0]                 console_data_o,
    output logic                       console_write_o,
    output logic                       frame_done_o
);

    // One spare bit on each counter so NUM_FIELDS == ROWS still fits.
    localparam int COL_W = $clog2(COLS + 1);
    localparam int ROW_W = $clog2(ROWS + 1);

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]  ROW_FIELDS = ROW_W'(NUM_FIELDS);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(COLS * ROWS - 1);

    // Scan pointer; addr_q tracks row*COLS+col incrementally so no multiplier
    // or divider is needed.
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [NUM_FIELDS*32-1:0] snap_q, snap_d;

    logic [ADDR_W-1:0]        out_addr_q, out_addr_d;
    logic [7:0]               out_data_q, out_data_d;
    logic                     out_write_q, out_write_d;
    logic                     frame_done_q, frame_done_d;

    logic [7:0]               cell_char;
    logic [31:0]              row_word;
    logic [15:0]              row_tag;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Character of the cell under the current (pre-advance) pointer.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cell_char = 8'h00;
        row_word  = 32'h0;
        row_tag   = 16'h0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (row_q == ROW_W'(k)) begin
                row_word = snap_q[k*32 +: 32];
                row_tag  = field_tag_i[k*16 +: 16];
            end
        end
        if (row_q < ROW_FIELDS) begin
            if (col_q == COL_W'(0))      cell_char = row_tag[15:8];
            else if (col_q == COL_W'(1)) cell_char = row_tag[7:0];
            else if (col_q == COL_W'(2)) cell_char = 8'h3A;
            else if (col_q == COL_W'(3)) cell_char = 8'h20;
            // Columns 4..11: most significant nibble first.
            for (int n = 0; n < 8; n++) begin
                if (col_q == COL_W'(4 + n)) cell_char = hex_char(row_word[31-4*n -: 4]);
            end
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        snap_d       = snap_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_write_d  = 1'b0;
        frame_done_d = 1'b0;
        if (enable_i) begin
            out_addr_d   = addr_q;
            out_data_d   = cell_char;
            out_write_d  = 1'b1;
            frame_done_d = (addr_q == ADDR_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            // Cell 0 is a tag cell, so refreshing the snapshot on this edge
            // never disturbs a hex digit of the frame being started.
            if ((addr_q == '0) && !freeze_i) snap_d = field_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // The snapshot is reset too: a frozen first frame must show zeros, not X.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            snap_q       <= '0;
            out_addr_q   <= '0;
            out_data_q   <= 8'h00;
            out_write_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            snap_q       <= snap_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_write_q  <= out_write_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign console_addr_o  = out_addr_q;
    assign console_data_o  = out_data_q;
    assign console_write_o = out_write_q;
    assign frame_done_o    = frame_done_q;

endmodule

// File: tb/tb_debug_console.sv
// -----------------------------------------------------------------------------
// tb_debug_console
//
// Drives a default-parameter debug_console and a small (1 field, 16x2) one.
// Each enabled cycle pushes the expected {addr, data, frame_done} from a
// division-based reference model onto a queue; the written cell is popped and
// compared one cycle later. Row text is also assembled from the DUT writes and
// compared against literal strings.
// -----------------------------------------------------------------------------
module tb_debug_console;

    localparam int NF    = 4;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int TOTAL = COLS * ROWS;

    localparam int NF2    = 1;
    localparam int COLS2  = 16;
    localparam int ROWS2  = 2;
    localparam int AW2    = 5;
    localparam int TOTAL2 = COLS2 * ROWS2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, frz;
    logic [127:0]  fdata;
    logic [63:0]   ftag;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          wr, done;

    logic           en2, frz2;
    logic [31:0]    fdata2;
    logic [15:0]    ftag2;
    logic [AW2-1:0] addr2;
    logic [7:0]     data2;
    logic           wr2, done2;

    debug_console #(.NUM_FIELDS(NF), .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .freeze_i(frz),
        .field_data_i(fdata), .field_tag_i(ftag),
        .console_addr_o(addr), .console_data_o(data),
        .console_write_o(wr), .frame_done_o(done)
    );

    debug_console #(.NUM_FIELDS(NF2), .COLS(COLS2), .ROWS(ROWS2), .ADDR_W(AW2)) dut_small (
        .clk_i(clk), .rst_i(rst), .enable_i(en2), .freeze_i(frz2),
        .field_data_i(fdata2), .field_tag_i(ftag2),
        .console_addr_o(addr2), .console_data_o(data2),
        .console_write_o(wr2), .frame_done_o(done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference cell content derived from the linear address by div/mod.
    function automatic logic [7:0] model_char(input int a, input int cols, input int nf,
                                              input logic [127:0] snap, input logic [63:0] tags);
        int row, col;
        logic [31:0] w;
        logic [15:0] t;
        logic [3:0]  nib;
        string hx;
        hx  = "0123456789ABCDEF";
        row = a / cols;
        col = a % cols;
        if (row >= nf || col >= 12) return 8'h00;
        w = snap[row*32 +: 32];
        t = tags[row*16 +: 16];
        case (col)
            0:       return t[15:8];
            1:       return t[7:0];
            2:       return 8'h3A;
            3:       return 8'h20;
            default: begin
                nib = w[(11-col)*4 +: 4];
                return hx[nib];
            end
        endcase
    endfunction

    // Main-instance scoreboard and model state.
    logic [20:0]  sb_q[$];
    int           m_ptr;
    logic [127:0] m_snap;
    logic [20:0]  last_exp;
    logic [95:0]  row0_s, row1_s;

    // Small-instance scoreboard and model state.
    logic [13:0]  sb2_q[$];
    int           m_ptr2;
    logic [31:0]  m_snap2;
    logic [95:0]  r2_row0;
    int           done2_cnt;

    task automatic step(input logic e);
        logic [20:0] exp;
        int a;
        en = e;
        if (e) begin
            if (m_ptr == 0 && !frz) m_snap = fdata;
            sb_q.push_back({12'(m_ptr), model_char(m_ptr, COLS, NF, m_snap, ftag), m_ptr == TOTAL - 1});
            m_ptr = (m_ptr + 1) % TOTAL;
        end
        @(posedge clk);
        #1;
        if (e) begin
            check("write", wr, 1'b1);
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: got write with empty queue expected none");
            end else begin
                exp = sb_q.pop_front();
                check("cell", {addr, data, done}, exp);
                last_exp = exp;
                a = int'(addr);
                if (a < 12) row0_s[(11-a)*8 +: 8] = data;
                else if (a >= COLS && a < COLS + 12) row1_s[(11-(a-COLS))*8 +: 8] = data;
            end
        end else begin
            check("stall_write", wr, 1'b0);
            check("stall_hold", {addr, data, done}, {last_exp[20:1], 1'b0});
        end
    endtask

    task automatic step_small(input logic e);
        logic [13:0] exp;
        int a;
        en2 = e;
        if (e) begin
            if (m_ptr2 == 0 && !frz2) m_snap2 = fdata2;
            sb2_q.push_back({5'(m_ptr2),
                             model_char(m_ptr2, COLS2, NF2, {96'h0, m_snap2}, {48'h0, ftag2}),
                             m_ptr2 == TOTAL2 - 1});
            m_ptr2 = (m_ptr2 + 1) % TOTAL2;
        end
        @(posedge clk);
        #1;
        check("sweep_write", wr2, e);
        if (e) begin
            if (sb2_q.size() == 0) begin
                errors++;
                $display("FAIL sweep_scoreboard: got write with empty queue expected none");
            end else begin
                exp = sb2_q.pop_front();
                check("sweep_cell", {addr2, data2, done2}, exp);
                if (done2) done2_cnt++;
                a = int'(addr2);
                if (a < 12) r2_row0[(11-a)*8 +: 8] = data2;
            end
        end
    endtask

    task automatic run_frame(input int change_at, input int what);
        for (int i = 0; i < TOTAL; i++) begin
            step(1'b1);
            if (i == change_at) begin
                case (what)
                    1: fdata[63:32] = 32'hFFFF_FFFF;
                    2: begin frz = 1'b1; fdata[31:0] = 32'hDEAD_BEEF; end
                    3: frz = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        frz    = 1'b0;
        fdata  = {$urandom(), $urandom(), 32'h0, 32'h1234_ABCD};
        ftag   = {"R3", "R2", "R1", "PC"};
        en2    = 1'b0;
        frz2   = 1'b1;
        fdata2 = 32'h0F1E_2D3C;
        ftag2  = "A0";
        m_ptr  = 0;
        m_snap = '0;
        m_ptr2 = 0;
        m_snap2 = '0;
        last_exp = '0;
        row0_s = '0;
        row1_s = '0;
        r2_row0 = '0;
        done2_cnt = 0;

        #2;
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_write", wr, 0);
        check("rst_done", done, 0);
        check("rst_small", {addr2, data2, wr2, done2}, 0);

        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame 1: field1 changes while row 0 is being written.
        run_frame(20, 1);
        check("f1_row0", row0_s, "PC: 1234ABCD");
        check("f1_row1", row1_s, "R1: 00000000");

        // Frame 2: new field1 visible; freeze raised and field0 changed mid-frame.
        run_frame(1000, 2);
        check("f2_row0", row0_s, "PC: 1234ABCD");
        check("f2_row1", row1_s, "R1: FFFFFFFF");

        // Frames 3 and 4 start frozen; freeze drops late in frame 4.
        run_frame(-1, 0);
        check("f3_row0_frozen", row0_s, "PC: 1234ABCD");
        run_frame(1500, 3);
        check("f4_row0_frozen", row0_s, "PC: 1234ABCD");

        // Frame 5: new value, a 5-cycle stall after addr 300, reset after addr 1000.
        for (int i = 0; i <= 1000; i++) begin
            step(1'b1);
            if (i == 300) repeat (5) step(1'b0);
            if (i == 11) check("f5_row0", row0_s, "PC: DEADBEEF");
        end
        check("pre_rst_addr", addr, 1000);

        #3 rst = 1'b1;
        #1;
        check("mid_rst_addr", addr, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_write", wr, 0);
        check("mid_rst_done", done, 0);
        sb_q.delete();
        m_ptr = 0;
        m_snap = '0;
        fdata[31:0] = 32'hCAFE_F00D;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) step(1'b1);
        check("post_rst_row0", row0_s, "PC: CAFEF00D");
        en = 1'b0;

        // Small instance: first frame frozen from reset (zero snapshot), second live.
        for (int i = 0; i < TOTAL2; i++) begin
            step_small(1'b1);
            if (i == 20) frz2 = 1'b0;
        end
        check("sweep_f1_row0", r2_row0, "A0: 00000000");
        for (int i = 0; i < TOTAL2; i++) step_small(1'b1);
        check("sweep_f2_row0", r2_row0, "A0: 0F1E2D3C");
        check("sweep_done_cnt", done2_cnt, 2);
        step_small(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_console.md
DEBUG_CONSOLE -- requirements
Module: debug_console

Interface
REQ-001 The block SHALL have parameter NUM_FIELDS, default 4, giving the number of 32-bit fields displayed; legal range 1..ROWS.
REQ-002 The block SHALL have parameter COLS, default 80, giving characters per console row; minimum 12.
REQ-003 The block SHALL have parameter ROWS, default 30, giving console rows.
REQ-004 The block SHALL have parameter ADDR_W, default 12, giving console address width; COLS*ROWS SHALL be at most 2^ADDR_W.
REQ-005 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  scanner advances only when high.
REQ-009 freeze  input  1  when high, inhibits the frame-start snapshot.
REQ-010 field_data  input  NUM_FIELDS*32  packed fields; field k is bits [32k+31:32k].
REQ-011 field_tag  input  NUM_FIELDS*16  two ASCII label characters per field; bits [16k+15:16k+8] are the first character.
REQ-012 console_addr  output  ADDR_W  character-cell address being written.
REQ-013 console_data  output  8  ASCII character for console_addr.
REQ-014 console_write  output  1  write strobe for console_addr/console_data.
REQ-015 frame_done  output  1  one-cycle pulse marking the last cell of a frame.

Function
REQ-016 The block SHALL keep an internal scan pointer (row, col), with col counting 0..COLS-1 and row counting 0..ROWS-1, so that no divider is needed.
REQ-017 Pointer stepping: on each rising edge with enable high, col increments; at COLS-1, col wraps to 0 and row increments; at (ROWS-1, COLS-1) both wrap to 0.
REQ-018 Outputs are registered: on each rising edge with enable high, the block SHALL drive console_addr = row*COLS+col of the pre-advance pointer, console_data = that cell's character, and console_write = 1.
REQ-019 When enable is low at an edge, the block SHALL hold the pointer, force console_write = 0, hold console_addr/console_data, and force frame_done = 0.
REQ-020 For a row r < NUM_FIELDS, the cell characters SHALL be:
- col 0: first tag character;
- col 1: second tag character;
- col 2: ':' (0x3A);
- col 3: ' ' (0x20);
- cols 4..11: snapshot field r nibbles, bits [31:28] first and [3:0] last;
- cols >= 12: 0x00.
REQ-021 Rows r >= NUM_FIELDS SHALL be written as 0x00 in every column.
REQ-022 Nibble encoding SHALL be 0..9 -> 0x30..0x39 and A..F -> 0x41..0x46 (uppercase).
REQ-023 Snapshot capture: on the enabled edge that issues address 0, all of field_data SHALL be captured into a snapshot register, unless freeze is high at that edge.
REQ-024 The whole frame SHALL display the snapshot only; changes to field_data mid-frame SHALL NOT appear until the next capture.
REQ-025 field_tag SHALL be sampled live when each tag cell is issued (no snapshot).
REQ-026 Freeze with enable: with freeze high, the snapshot SHALL be retained indefinitely while the scanner keeps refreshing the console.
REQ-027 frame_done SHALL be 1 exactly on the enabled edge that issues address COLS*ROWS-1, and 0 otherwise.
REQ-028 Steady-state throughput SHALL be one cell per enabled cycle; a full frame takes COLS*ROWS enabled cycles.

Reset
REQ-029 Reset asserted SHALL immediately force:
- pointer to (0,0);
- console_addr = 0, console_data = 0x00;
- console_write = 0, frame_done = 0;
- snapshot = 0.
REQ-030 Reset mid-frame SHALL abandon the frame.
REQ-031 After reset is released, the first enabled edge SHALL issue address 0 and capture the snapshot, subject to freeze.

Verification
REQ-032 Frame write: defaults, field0=0x1234ABCD, tag0="PC", enable=1 after reset -> addr 0..11 carry "PC: 1234ABCD", addr 12..79 = 0x00, addr 2399 coincides with frame_done=1, next addr = 0.
REQ-033 Snapshot coherence: field1 changes 0x0 -> 0xFFFFFFFF while row 0 is being issued -> row 1 shows "00000000" in the current frame and "FFFFFFFF" in the next frame.
REQ-034 Freeze: freeze=1 across two frame starts while field0 changes -> row 0 hex is unchanged; deassert freeze -> new value appears from the following frame.
REQ-035 Stall: enable=0 for 5 cycles at addr 300 -> console_write=0 for those cycles, addr and data held; resume issues addr 301 next.
REQ-036 Reset mid-operation: assert reset at addr 1000 -> outputs zero asynchronously; after release, first write is addr 0 with new snapshot.
REQ-037 Parameter sweep: NUM_FIELDS=1, COLS=16, ROWS=2 -> frame is 32 cells, row 1 all 0x00, frame_done on addr 31.
